sdr_arbiter: RTL and testbench

//  Shares the single user port of the SDRAM controller between two requesters.

---
 rtl/sdr_arb_pkg.sv | 16 +
 rtl/sdr_arb_pick.sv | 48 ++++
 rtl/sdr_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_arb_pkg.sv
// Shared constants for the SDRAM user-port arbiter: FSM state encoding,
// requester port identifiers and default bus widths.
package sdr_arb_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sdr_arb_pick.sv
// Grant selection between the two requesters. Port 0 wins ties until it has
// collected MAX_STREAK consecutive grants while port 1 was waiting.
module sdr_arb_pick
    import sdr_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p0_valid,
    input  logic       p1_valid,
    input  logic       idle,
    output logic       grant,
    output logic [1:0] ready
);

    localparam int SW = $clog2(MAX_STREAK + 2);

    logic [SW-1:0] streak;

    always_comb begin
        grant = PORT0;
        if (p1_valid && (!p0_valid || streak == SW'(MAX_STREAK))) begin
            grant = PORT1;
        end
        ready = 2'b00;
        if (idle) begin
            ready[0] = p0_valid && (grant == PORT0);
            ready[1] = p1_valid && (grant == PORT1);
        end
    end

    // Streak only grows while port 1 is actually being held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (ready[1]) begin
            streak <= '0;
        end else if (ready[0]) begin
            if (!p1_valid) begin
                streak <= '0;
            end else if (streak != SW'(MAX_STREAK)) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdr_arbiter.sv
// Shares the SDRAM controller's single user port between a priority CPU port
// and a DMA port, serialising transactions and routing completions back.
module sdr_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_rw,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic              ctrl_in_valid,
    input  logic              ctrl_busy,
    input  logic [DATA_W-1:0] ctrl_rdata,
    input  logic              ctrl_out_valid,
    output logic              unexp_rsp
);

    localparam int WD_W = $clog2(TIMEOUT + 2);

    logic [1:0]        state;
    logic              owner;
    logic              rd_seen;
    logic [DATA_W-1:0] rd_buf;
    logic [WD_W-1:0]   wd;
    logic              grant;
    logic [1:0]        ready;
    logic              idle;
    logic              rd_done;
    logic              wr_done;
    logic              timed_out;
    logic              fin;
    logic [DATA_W-1:0] rsp_data;

    // Outputs are forced quiet while reset is held, even though state is registered.
    assign idle          = (state == ST_IDLE) && !rst;
    assign ctrl_in_valid = (state == ST_ISSUE) && !ctrl_busy && !rst;
    assign p0_ready      = ready[0];
    assign p1_ready      = ready[1];

    sdr_arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .p0_valid (p0_valid),
        .p1_valid (p1_valid),
        .idle     (idle),
        .grant    (grant),
        .ready    (ready)
    );

    // A real completion in the same cycle as the watchdog expiry takes precedence.
    always_comb begin
        rd_done   = (state == ST_WAIT) && !ctrl_rw && (ctrl_out_valid || rd_seen);
        wr_done   = (state == ST_WAIT) && ctrl_rw && !ctrl_busy;
        timed_out = ((state == ST_GUARD) || (state == ST_WAIT)) &&
                    (wd == WD_W'(TIMEOUT)) && !rd_done && !wr_done;
        fin       = rd_done || wr_done || timed_out;
        rsp_data  = rd_seen ? rd_buf : ctrl_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= PORT0;
            rd_seen    <= 1'b0;
            rd_buf     <= '0;
            wd         <= '0;
            ctrl_addr  <= '0;
            ctrl_rw    <= 1'b0;
            ctrl_wdata <= '0;
            p0_done    <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_done    <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
            unexp_rsp  <= 1'b0;
        end else begin
            p0_done <= 1'b0;
            p0_err  <= 1'b0;
            p1_done <= 1'b0;
            p1_err  <= 1'b0;
            if (ctrl_out_valid && (state == ST_IDLE || state == ST_ISSUE)) begin
                unexp_rsp <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (|ready) begin
                        owner      <= grant;
                        ctrl_rw    <= (grant == PORT1) ? p1_rw    : p0_rw;
                        ctrl_addr  <= (grant == PORT1) ? p1_addr  : p0_addr;
                        ctrl_wdata <= (grant == PORT1) ? p1_wdata : p0_wdata;
                        rd_seen    <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!ctrl_busy) begin
                        wd    <= '0;
                        state <= ST_GUARD;
                    end
                end
                default: begin
                    // Fast read data can land while busy is still low in GUARD.
                    if (state == ST_GUARD && !ctrl_rw && ctrl_out_valid) begin
                        rd_seen <= 1'b1;
                        rd_buf  <= ctrl_rdata;
                    end
                    if (fin) begin
                        state <= ST_IDLE;
                        if (owner == PORT1) begin
                            p1_done <= 1'b1;
                            p1_err  <= timed_out;
                            if (rd_done) p1_rdata <= rsp_data;
                        end else begin
                            p0_done <= 1'b1;
                            p0_err  <= timed_out;
                            if (rd_done) p0_rdata <= rsp_data;
                        end
                    end else begin
                        wd    <= wd + 1'b1;
                        state <= ST_WAIT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_arbiter.sv
// Directed bench for sdr_arbiter with a small behavioural SDRAM controller
// whose read latency and busy length are set per scenario.
module tb_sdr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_valid = 1'b0, p0_rw = 1'b0, p1_valid = 1'b0, p1_rw = 1'b0;
    logic [22:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_ready, p0_done, p0_err, p1_ready, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [22:0] ctrl_addr;
    logic        ctrl_rw, ctrl_in_valid, ctrl_busy, unexp_rsp;
    logic [31:0] ctrl_wdata;
    logic [31:0] ctrl_rdata = '0;
    logic        ctrl_out_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sdr_arbiter #(.ADDR_W(23), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rw(p0_rw), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rw(p1_rw), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy), .ctrl_rdata(ctrl_rdata),
        .ctrl_out_valid(ctrl_out_valid), .unexp_rsp(unexp_rsp)
    );

    always @(posedge clk) cyc++;

    // Controller model: out_valid rsp_lat cycles after in_valid (0 = never),
    // busy high for busy_len cycles starting two cycles after in_valid.
    int          rsp_lat = 0, busy_len = 0, rsp_cnt = 0, busy_cnt = 0;
    logic [31:0] rsp_data = '0;
    logic        iv_prev = 1'b0, hold_busy = 1'b0, mdl_busy = 1'b0;

    always @(negedge clk) iv_prev = ctrl_in_valid;

    always @(posedge clk) begin
        #1;
        if (iv_prev) begin
            rsp_cnt  = rsp_lat;
            busy_cnt = (busy_len > 0) ? busy_len + 1 : 0;
        end
        ctrl_out_valid = (rsp_cnt == 1);
        ctrl_rdata     = (rsp_cnt == 1) ? rsp_data : 32'h0;
        mdl_busy       = (busy_cnt >= 1) && (busy_cnt <= busy_len);
        if (rsp_cnt > 0) rsp_cnt--;
        if (busy_cnt > 0) busy_cnt--;
    end

    assign ctrl_busy = hold_busy | mdl_busy;

    int          iv_cnt = 0, last_iv = 0, d0_cnt = 0, d1_cnt = 0, last_d0 = 0, last_d1 = 0, both_rdy = 0;
    logic [22:0] iv_addr = '0;
    logic        iv_rw = 1'b0;
    logic [31:0] iv_wdata = '0;

    always @(negedge clk) begin
        if (ctrl_in_valid) begin
            iv_cnt++;
            last_iv  = cyc;
            iv_addr  = ctrl_addr;
            iv_rw    = ctrl_rw;
            iv_wdata = ctrl_wdata;
        end
        if (p0_done) begin d0_cnt++; last_d0 = cyc; end
        if (p1_done) begin d1_cnt++; last_d1 = cyc; end
        if (p0_ready && p1_ready) both_rdy++;
    end

    task automatic send(input bit port, input bit rw, input logic [22:0] addr,
                        input logic [31:0] wdata, output bit ok);
        bit rdy;
        ok = 1'b0;
        if (port) begin p1_valid = 1; p1_rw = rw; p1_addr = addr; p1_wdata = wdata; end
        else      begin p0_valid = 1; p0_rw = rw; p0_addr = addr; p0_wdata = wdata; end
        for (int i = 0; i < 50; i++) begin
            #1;
            rdy = port ? p1_ready : p0_ready;
            @(posedge clk);
            @(negedge clk); #2;
            if (rdy) begin ok = 1'b1; break; end
        end
        if (port) p1_valid = 0; else p0_valid = 0;
    endtask

    task automatic wait_iv(input int base, output int cy, output bit ok);
        for (int i = 0; i < 40 && iv_cnt == base; i++) begin @(negedge clk); #2; end
        ok = (iv_cnt > base);
        cy = last_iv;
    endtask

    task automatic wait_done(input bit port, input int base, output int cy, output bit ok);
        for (int i = 0; i < 60 && (port ? d1_cnt : d0_cnt) == base; i++) begin @(negedge clk); #2; end
        ok = (port ? d1_cnt : d0_cnt) > base;
        cy = port ? last_d1 : last_d0;
    endtask

    task automatic test_reset();
        rst = 1; p0_valid = 1; p1_valid = 1;
        repeat (3) @(negedge clk);
        #2;
        total++; if ({p0_ready, p1_ready, ctrl_in_valid} !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", {p0_ready, p1_ready, ctrl_in_valid}); end
        total++; if ({ctrl_addr, ctrl_rw, ctrl_wdata} !== 56'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", {ctrl_addr, ctrl_rw, ctrl_wdata}); end
        total++; if ({p0_done, p0_err, p0_rdata, p1_done, p1_err, p1_rdata, unexp_rsp} !== 69'h0) begin bad++; $display("FAIL reset_rsp got=%h want=0", {p0_done, p0_err, p0_rdata, p1_done, p1_err, p1_rdata, unexp_rsp}); end
        p0_valid = 0; p1_valid = 0; rst = 0;
        repeat (3) @(negedge clk);
        #2;
        total++; if (iv_cnt !== 0) begin bad++; $display("FAIL reset_no_issue got=%0d want=0", iv_cnt); end
    endtask

    task automatic test_p0_read();
        int bi, b0, b1, ti, td; bit ok;
        bi = iv_cnt; b0 = d0_cnt; b1 = d1_cnt;
        rsp_lat = 4; busy_len = 0; rsp_data = 32'hDEADBEEF;
        send(0, 0, 23'h000010, 32'h0, ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_accept got=0 want=1"); end
        wait_iv(bi, ti, ok);
        total++; if (!ok || iv_addr !== 23'h000010 || iv_rw !== 1'b0) begin bad++; $display("FAIL rd_issue got=%h/%b want=000010/0", iv_addr, iv_rw); end
        wait_done(0, b0, td, ok);
        total++; if (!ok || td !== ti + 5) begin bad++; $display("FAIL rd_done_cycle got=%0d want=%0d", td - ti, 5); end
        total++; if (p0_rdata !== 32'hDEADBEEF || p0_err !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%b want=deadbeef/0", p0_rdata, p0_err); end
        @(negedge clk); #2;
        total++; if (p0_done !== 1'b0 || d1_cnt !== b1 || iv_cnt !== bi + 1) begin bad++; $display("FAIL rd_single got=%b/%0d/%0d want=0/%0d/%0d", p0_done, d1_cnt, iv_cnt, b1, bi + 1); end
    endtask

    task automatic test_p1_write();
        int bi, b0, b1, ti, td; bit ok;
        bi = iv_cnt; b0 = d0_cnt; b1 = d1_cnt;
        rsp_lat = 2; busy_len = 3; hold_busy = 1;
        send(1, 1, 23'h7FFFFF, 32'h12345678, ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_accept got=0 want=1"); end
        repeat (3) @(negedge clk);
        #2;
        total++; if (iv_cnt !== bi) begin bad++; $display("FAIL wr_hold_busy got=%0d want=%0d", iv_cnt, bi); end
        @(posedge clk); #1; hold_busy = 0;
        wait_iv(bi, ti, ok);
        total++; if (!ok || iv_wdata !== 32'h12345678 || iv_addr !== 23'h7FFFFF || iv_rw !== 1'b1) begin bad++; $display("FAIL wr_issue got=%h/%h/%b want=12345678/7fffff/1", iv_wdata, iv_addr, iv_rw); end
        wait_done(1, b1, td, ok);
        total++; if (!ok || td !== ti + 6 || p1_err !== 1'b0) begin bad++; $display("FAIL wr_done_cycle got=%0d/%b want=6/0", td - ti, p1_err); end
        total++; if (d0_cnt !== b0 || p0_rdata !== 32'hDEADBEEF || unexp_rsp !== 1'b0) begin bad++; $display("FAIL wr_p0_quiet got=%0d/%h/%b want=%0d/deadbeef/0", d0_cnt, p0_rdata, unexp_rsp, b0); end
    endtask

    task automatic test_streak();
        int exp_order[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        int order[12];
        int g, nv, last, gap, bd0, bd1;
        g = 0; nv = 0; last = -1; gap = 1000; bd0 = d0_cnt; bd1 = d1_cnt;
        rsp_lat = 0; busy_len = 0;
        p0_rw = 1; p0_addr = 23'h000100; p0_wdata = 32'hA0A0A0A0;
        p1_rw = 1; p1_addr = 23'h000200; p1_wdata = 32'hB1B1B1B1;
        p0_valid = 1; p1_valid = 1;
        #1;
        for (int c = 0; c < 300 && (d0_cnt + d1_cnt - bd0 - bd1) < 12; c++) begin
            if (g < 12) begin
                if (p0_ready) begin order[g] = 0; g++; end
                else if (p1_ready) begin order[g] = 1; g++; end
            end else begin
                p0_valid = 0; p1_valid = 0;
            end
            if (ctrl_in_valid) begin
                if (last >= 0 && cyc - last < gap) gap = cyc - last;
                last = cyc; nv++;
            end
            @(negedge clk); #2;
        end
        p0_valid = 0; p1_valid = 0;
        for (int i = 0; i < 12; i++) begin
            total++; if (i >= g || order[i] !== exp_order[i]) begin bad++; $display("FAIL streak_grant%0d got=%0d want=%0d", i, (i < g) ? order[i] : -1, exp_order[i]); end
        end
        total++; if (nv !== 12 || gap !== 4) begin bad++; $display("FAIL streak_spacing got=%0d/%0d want=12/4", nv, gap); end
        total++; if (both_rdy !== 0 || d0_cnt - bd0 !== 10 || d1_cnt - bd1 !== 2) begin bad++; $display("FAIL streak_counts got=%0d/%0d/%0d want=0/10/2", both_rdy, d0_cnt - bd0, d1_cnt - bd1); end
    endtask

    task automatic test_cache_hit();
        int bi, b1, ti, td; bit ok;
        bi = iv_cnt; b1 = d1_cnt;
        rsp_lat = 1; busy_len = 0; rsp_data = 32'hCAFEF00D;
        send(1, 0, 23'h000055, 32'h0, ok);
        wait_iv(bi, ti, ok);
        wait_done(1, b1, td, ok);
        total++; if (!ok || td !== ti + 3) begin bad++; $display("FAIL hit_done_cycle got=%0d want=3", td - ti); end
        total++; if (p1_rdata !== 32'hCAFEF00D || p1_err !== 1'b0) begin bad++; $display("FAIL hit_data got=%h/%b want=cafef00d/0", p1_rdata, p1_err); end
        repeat (8) @(negedge clk);
        #2;
        total++; if (d1_cnt !== b1 + 1 || unexp_rsp !== 1'b0) begin bad++; $display("FAIL hit_single got=%0d/%b want=%0d/0", d1_cnt, unexp_rsp, b1 + 1); end
    endtask

    task automatic test_timeout();
        int bi, b0, ti, td; bit ok;
        bi = iv_cnt; b0 = d0_cnt;
        rsp_lat = 0; busy_len = 0;
        send(0, 0, 23'h000020, 32'h0, ok);
        wait_iv(bi, ti, ok);
        wait_done(0, b0, td, ok);
        total++; if (!ok || td !== ti + 17) begin bad++; $display("FAIL to_done_cycle got=%0d want=17", td - ti); end
        total++; if (p0_err !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL to_err got=%b/%h want=1/deadbeef", p0_err, p0_rdata); end
        @(negedge clk); #2;
        total++; if (p0_err !== 1'b0 || p0_done !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b/%b want=0/0", p0_err, p0_done); end
        bi = iv_cnt; b0 = d0_cnt;
        rsp_lat = 3; rsp_data = 32'h0BADCAFE;
        send(0, 0, 23'h000021, 32'h0, ok);
        wait_iv(bi, ti, ok);
        wait_done(0, b0, td, ok);
        total++; if (!ok || td !== ti + 4 || p0_rdata !== 32'h0BADCAFE || p0_err !== 1'b0) begin bad++; $display("FAIL to_recover got=%0d/%h/%b want=4/0badcafe/0", td - ti, p0_rdata, p0_err); end
    endtask

    task automatic test_withdraw();
        int bi, b0, b1, ti, td; bit ok, rdy;
        bi = iv_cnt; b0 = d0_cnt; b1 = d1_cnt;
        rsp_lat = 5; busy_len = 0; rsp_data = 32'h11112222;
        send(0, 0, 23'h000040, 32'h0, ok);
        wait_iv(bi, ti, ok);
        @(negedge clk); #2;
        p1_valid = 1; p1_rw = 0; p1_addr = 23'h000041;
        #1; rdy = p1_ready;
        @(negedge clk); #2;
        p1_valid = 0;
        wait_done(0, b0, td, ok);
        repeat (6) @(negedge clk);
        #2;
        total++; if (rdy !== 1'b0 || iv_cnt !== bi + 1 || d1_cnt !== b1) begin bad++; $display("FAIL withdraw got=%b/%0d/%0d want=0/%0d/%0d", rdy, iv_cnt, d1_cnt, bi + 1, b1); end
        total++; if (!ok || p0_rdata !== 32'h11112222) begin bad++; $display("FAIL withdraw_rd got=%h want=11112222", p0_rdata); end
    endtask

    task automatic test_reset_mid();
        int bi, b0, ti, td; bit ok;
        bi = iv_cnt; b0 = d0_cnt;
        rsp_lat = 6; busy_len = 0; rsp_data = 32'h77778888;
        send(0, 0, 23'h000030, 32'h0, ok);
        wait_iv(bi, ti, ok);
        repeat (3) @(negedge clk);
        #2;
        rst = 1;
        @(negedge clk); #2;
        total++; if ({ctrl_addr, ctrl_rw, ctrl_in_valid, p0_rdata, p0_done} !== 58'h0) begin bad++; $display("FAIL midrst_outputs got=%h want=0", {ctrl_addr, ctrl_rw, ctrl_in_valid, p0_rdata, p0_done}); end
        rst = 0;
        repeat (5) @(negedge clk);
        #2;
        total++; if (d0_cnt !== b0 || unexp_rsp !== 1'b1) begin bad++; $display("FAIL midrst_drop got=%0d/%b want=%0d/1", d0_cnt, unexp_rsp, b0); end
        bi = iv_cnt; b0 = d0_cnt;
        rsp_lat = 4; rsp_data = 32'h9999AAAA;
        send(0, 0, 23'h000031, 32'h0, ok);
        wait_iv(bi, ti, ok);
        wait_done(0, b0, td, ok);
        total++; if (!ok || td !== ti + 5 || p0_rdata !== 32'h9999AAAA || unexp_rsp !== 1'b1) begin bad++; $display("FAIL midrst_next got=%0d/%h/%b want=5/9999aaaa/1", td - ti, p0_rdata, unexp_rsp); end
    endtask

    initial begin
        test_reset();
        test_p0_read();
        test_p1_write();
        test_streak();
        test_cache_hit();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
